// File: rtl/tm_poll_depth_mc.sv
// Multi-channel queue-depth poller: round-robin arbitration of N_CH pollers onto one
// depth lookup port, in-order tag/info tracking and drop/mark verdict per poll.
module tm_poll_depth_mc #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned QID_NBITS = 8,
    parameter int unsigned DEP_NBITS = 8,
    parameter int unsigned MAX_OUTST = 6,
    parameter bit          CMP_GE    = 1'b0,
    localparam int unsigned CH_W     = $clog2(N_CH),
    localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_CH-1:0]           poll_req,
    input  logic [N_CH*QID_NBITS-1:0] poll_qid,
    output logic [N_CH-1:0]           poll_gnt,
    input  logic                      ll_ack,
    input  logic                      ll_drop,
    input  logic [DEP_NBITS:0]        ll_thr,
    input  logic [DEP_NBITS:0]        ll_mark_thr,
    output logic                      queue_depth_req,
    output logic [QID_NBITS-1:0]      queue_id,
    input  logic                      queue_depth_ack,
    input  logic [DEP_NBITS-1:0]      queue_depth,
    output logic [N_CH-1:0]           poll_ack,
    output logic                      poll_drop,
    output logic                      poll_mark,
    output logic [QID_NBITS-1:0]      poll_ack_qid,
    output logic [CNT_W-1:0]          outst_cnt,
    output logic                      err_underrun
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Arbitration
    logic [CH_W-1:0]      rr_ptr;
    logic [CH_W-1:0]      gnt_ch;
    logic [CH_W-1:0]      cand_ch;
    logic [QID_NBITS-1:0] gnt_qid;
    logic                 gnt_any;
    logic                 grant_ok;

    // Depth return pipeline
    logic                 ack_d;
    logic [DEP_NBITS-1:0] depth_q;
    logic                 pop;

    // Tag FIFO: {channel, qid} per granted poll; occupancy is outst_cnt
    logic [CH_W-1:0]      tag_ch_mem  [MAX_OUTST];
    logic [QID_NBITS-1:0] tag_qid_mem [MAX_OUTST];
    logic [PTR_W-1:0]     tag_wr;
    logic [PTR_W-1:0]     tag_rd;

    // Info FIFO: link-list thresholds per poll
    logic                 info_drop_mem [MAX_OUTST];
    logic [DEP_NBITS:0]   info_thr_mem  [MAX_OUTST];
    logic [DEP_NBITS:0]   info_mthr_mem [MAX_OUTST];
    logic [PTR_W-1:0]     info_wr;
    logic [PTR_W-1:0]     info_rd;
    logic [CNT_W-1:0]     info_cnt;
    logic                 info_push;

    // Verdict
    logic [DEP_NBITS:0]   depth_ext;
    logic                 over_thr;
    logic                 drop_c;
    logic                 mark_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop       = ack_d && (outst_cnt != '0) && (info_cnt != '0);
    // A pop in the same cycle frees a slot, so a full tracker can still grant.
    assign grant_ok  = (outst_cnt < CNT_W'(MAX_OUTST)) || pop;
    assign info_push = ll_ack && ((info_cnt < CNT_W'(MAX_OUTST)) || pop);

    always_comb begin
        poll_gnt = '0;
        gnt_ch   = '0;
        gnt_any  = 1'b0;
        cand_ch  = '0;
        if (grant_ok) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cand_ch = CH_W'((32'(rr_ptr) + i) % N_CH);
                if (!gnt_any && poll_req[cand_ch]) begin
                    gnt_any           = 1'b1;
                    gnt_ch            = cand_ch;
                    poll_gnt[cand_ch] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_qid = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == gnt_ch) begin
                gnt_qid = poll_qid[i*QID_NBITS +: QID_NBITS];
            end
        end
    end

    always_comb begin
        depth_ext = {1'b0, depth_q};
        over_thr  = CMP_GE ? (depth_ext >= info_thr_mem[info_rd])
                           : (depth_ext >  info_thr_mem[info_rd]);
        drop_c    = info_drop_mem[info_rd] | over_thr;
        mark_c    = !drop_c && (depth_ext > info_mthr_mem[info_rd]);
    end

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            tag_ch_mem[tag_wr]  <= gnt_ch;
            tag_qid_mem[tag_wr] <= gnt_qid;
        end
        if (info_push) begin
            info_drop_mem[info_wr] <= ll_drop;
            info_thr_mem[info_wr]  <= ll_thr;
            info_mthr_mem[info_wr] <= ll_mark_thr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr          <= '0;
            tag_wr          <= '0;
            tag_rd          <= '0;
            info_wr         <= '0;
            info_rd         <= '0;
            info_cnt        <= '0;
            outst_cnt       <= '0;
            ack_d           <= 1'b0;
            depth_q         <= '0;
            queue_depth_req <= 1'b0;
            queue_id        <= '0;
            poll_ack        <= '0;
            poll_drop       <= 1'b0;
            poll_mark       <= 1'b0;
            poll_ack_qid    <= '0;
            err_underrun    <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_ptr   <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
                tag_wr   <= ptr_inc(tag_wr);
                queue_id <= gnt_qid;
            end
            queue_depth_req <= gnt_any;

            case ({gnt_any, pop})
                2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
                2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
                default: outst_cnt <= outst_cnt;
            endcase

            if (info_push) begin
                info_wr <= ptr_inc(info_wr);
            end
            case ({info_push, pop})
                2'b10:   info_cnt <= info_cnt + CNT_W'(1);
                2'b01:   info_cnt <= info_cnt - CNT_W'(1);
                default: info_cnt <= info_cnt;
            endcase

            ack_d   <= queue_depth_ack;
            depth_q <= queue_depth;

            poll_ack <= '0;
            if (pop) begin
                tag_rd       <= ptr_inc(tag_rd);
                info_rd      <= ptr_inc(info_rd);
                poll_ack     <= N_CH'(1) << tag_ch_mem[tag_rd];
                poll_drop    <= drop_c;
                poll_mark    <= mark_c;
                poll_ack_qid <= tag_qid_mem[tag_rd];
            end

            if (ack_d && !pop) begin
                err_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tm_poll_depth_mc.sv
// Directed bench for tm_poll_depth_mc: one instance per compare mode (> and >=)
// driven from the same stimulus, table-driven single polls plus multi-cycle sequences.
module tb_tm_poll_depth_mc;

    logic        clk;
    logic        rstn;
    logic [3:0]  poll_req;
    logic [31:0] poll_qid;
    logic        ll_ack;
    logic        ll_drop;
    logic [8:0]  ll_thr;
    logic [8:0]  ll_mark_thr;
    logic        queue_depth_ack;
    logic [7:0]  queue_depth;

    logic [3:0] gnt_a,    gnt_b;
    logic       qreq_a,   qreq_b;
    logic [7:0] qid_a,    qid_b;
    logic [3:0] ack_a,    ack_b;
    logic       drop_a,   drop_b;
    logic       mark_a,   mark_b;
    logic [7:0] ackqid_a, ackqid_b;
    logic [2:0] outst_a,  outst_b;
    logic       err_a,    err_b;

    int n_chk  = 0;
    int n_fail = 0;

    tm_poll_depth_mc #(
        .N_CH(4), .QID_NBITS(8), .DEP_NBITS(8), .MAX_OUTST(6), .CMP_GE(1'b0)
    ) u_gt (
        .clk(clk), .rstn(rstn), .poll_req(poll_req), .poll_qid(poll_qid),
        .poll_gnt(gnt_a), .ll_ack(ll_ack), .ll_drop(ll_drop), .ll_thr(ll_thr),
        .ll_mark_thr(ll_mark_thr), .queue_depth_req(qreq_a), .queue_id(qid_a),
        .queue_depth_ack(queue_depth_ack), .queue_depth(queue_depth),
        .poll_ack(ack_a), .poll_drop(drop_a), .poll_mark(mark_a),
        .poll_ack_qid(ackqid_a), .outst_cnt(outst_a), .err_underrun(err_a)
    );

    tm_poll_depth_mc #(
        .N_CH(4), .QID_NBITS(8), .DEP_NBITS(8), .MAX_OUTST(6), .CMP_GE(1'b1)
    ) u_ge (
        .clk(clk), .rstn(rstn), .poll_req(poll_req), .poll_qid(poll_qid),
        .poll_gnt(gnt_b), .ll_ack(ll_ack), .ll_drop(ll_drop), .ll_thr(ll_thr),
        .ll_mark_thr(ll_mark_thr), .queue_depth_req(qreq_b), .queue_id(qid_b),
        .queue_depth_ack(queue_depth_ack), .queue_depth(queue_depth),
        .poll_ack(ack_b), .poll_drop(drop_b), .poll_mark(mark_b),
        .poll_ack_qid(ackqid_b), .outst_cnt(outst_b), .err_underrun(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1);
    end

    typedef struct {
        int         ch;
        logic [7:0] qid;
        logic       lld;
        logic [8:0] thr;
        logic [8:0] mthr;
        logic [7:0] depth;
        logic       d_gt;
        logic       d_ge;
        logic       m_gt;
        logic       m_ge;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        poll_req        = '0;
        poll_qid        = '0;
        ll_ack          = 1'b0;
        ll_drop         = 1'b0;
        ll_thr          = '0;
        ll_mark_thr     = '0;
        queue_depth_ack = 1'b0;
        queue_depth     = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One isolated poll: grant at T, lookup at T+1 answered combinationally (C=T+1), verdict at C+2.
    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.ch;
        @(negedge clk);
        poll_req            = onehot;
        poll_qid            = '0;
        poll_qid[v.ch*8 +: 8] = v.qid;
        #1;
        chk({tag, " gnt"}, 32'(gnt_a), 32'(onehot));
        chk({tag, " gnt_ge"}, 32'(gnt_b), 32'(onehot));
        @(negedge clk);
        poll_req = '0;
        chk({tag, " qreq"}, 32'(qreq_a), 32'd1);
        chk({tag, " qid_out"}, 32'(qid_a), 32'(v.qid));
        chk({tag, " qreq_ge"}, 32'(qreq_b), 32'd1);
        chk({tag, " qid_out_ge"}, 32'(qid_b), 32'(v.qid));
        chk({tag, " outst_inflight"}, 32'(outst_a), 32'd1);
        ll_ack          = 1'b1;
        ll_drop         = v.lld;
        ll_thr          = v.thr;
        ll_mark_thr     = v.mthr;
        queue_depth_ack = 1'b1;
        queue_depth     = v.depth;
        @(negedge clk);
        ll_ack          = 1'b0;
        queue_depth_ack = 1'b0;
        chk({tag, " ack_early"}, 32'(ack_a), 32'd0);
        chk({tag, " qreq_single"}, 32'(qreq_a), 32'd0);
        @(negedge clk);
        chk({tag, " ack"}, 32'(ack_a), 32'(onehot));
        chk({tag, " ack_ge"}, 32'(ack_b), 32'(onehot));
        chk({tag, " drop_gt"}, 32'(drop_a), 32'(v.d_gt));
        chk({tag, " drop_ge"}, 32'(drop_b), 32'(v.d_ge));
        chk({tag, " mark_gt"}, 32'(mark_a), 32'(v.m_gt));
        chk({tag, " mark_ge"}, 32'(mark_b), 32'(v.m_ge));
        chk({tag, " ack_qid"}, 32'(ackqid_a), 32'(v.qid));
        chk({tag, " ack_qid_ge"}, 32'(ackqid_b), 32'(v.qid));
        @(negedge clk);
        chk({tag, " ack_single"}, 32'(ack_a), 32'd0);
        chk({tag, " outst_done"}, 32'(outst_a), 32'd0);
        chk({tag, " outst_done_ge"}, 32'(outst_b), 32'd0);
        chk({tag, " no_err"}, 32'(err_a), 32'd0);
        chk({tag, " no_err_ge"}, 32'(err_b), 32'd0);
    endtask

    initial begin
        int   exp_d;
        logic e_drop;
        logic e_mark;

        //            ch  qid     lld   thr     mthr    depth   dgt dge mgt mge
        vecs[0] = '{0, 8'd5,   1'b0, 9'd10,  9'd20,  8'd11,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 8'd9,   1'b0, 9'd10,  9'd20,  8'd10,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2, 8'd33,  1'b0, 9'd10,  9'd4,   8'd8,   1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{3, 8'd77,  1'b1, 9'd10,  9'd4,   8'd8,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1, 8'd255, 1'b0, 9'd256, 9'd255, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2, 8'd0,   1'b0, 9'd255, 9'd0,   8'd255, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{0, 8'd128, 1'b0, 9'd0,   9'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{3, 8'd200, 1'b0, 9'd511, 9'd254, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1};

        clear_inputs();
        do_reset();

        @(negedge clk);
        chk("rst gnt", 32'(gnt_a), 32'd0);
        chk("rst ack", 32'(ack_a), 32'd0);
        chk("rst qreq", 32'(qreq_a), 32'd0);
        chk("rst outst", 32'(outst_a), 32'd0);
        chk("rst err", 32'(err_a), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // All channels requesting continuously, depth returned the cycle after each grant.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                chk($sformatf("rr qreq c%0d", c), 32'(qreq_a), 32'd1);
                chk($sformatf("rr qid c%0d", c), 32'(qid_a), 32'(10 + (c - 1) % 4));
            end
            if (c >= 3 && c <= 10) begin
                exp_d  = (c - 3) * 30;
                e_drop = (exp_d > 100);
                e_mark = !e_drop && (exp_d > 50);
                chk($sformatf("rr ack c%0d", c), 32'(ack_a), 32'(4'b0001 << ((c - 3) % 4)));
                chk($sformatf("rr ackqid c%0d", c), 32'(ackqid_a), 32'(10 + (c - 3) % 4));
                chk($sformatf("rr drop c%0d", c), 32'(drop_a), 32'(e_drop));
                chk($sformatf("rr drop_ge c%0d", c), 32'(drop_b), 32'(e_drop));
                chk($sformatf("rr mark c%0d", c), 32'(mark_a), 32'(e_mark));
            end else begin
                chk($sformatf("rr noack c%0d", c), 32'(ack_a), 32'd0);
            end
            poll_req = (c < 8) ? 4'hF : 4'h0;
            for (int k = 0; k < 4; k++) poll_qid[k*8 +: 8] = 8'(10 + k);
            queue_depth_ack = (c >= 1 && c <= 8);
            ll_ack          = (c >= 1 && c <= 8);
            queue_depth     = (c >= 1) ? 8'((c - 1) * 30) : 8'd0;
            ll_thr          = 9'd100;
            ll_mark_thr     = 9'd50;
            ll_drop         = 1'b0;
            #1;
            chk($sformatf("rr gnt c%0d", c), 32'(gnt_a), (c < 8) ? 32'(4'b0001 << (c % 4)) : 32'd0);
        end
        chk("rr outst end", 32'(outst_a), 32'd0);

        // Fill the tracker, then one return lets exactly one new grant through.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c <= 8) chk($sformatf("full outst c%0d", c), 32'(outst_a), 32'((c < 6) ? c : 6));
            if (c == 7) chk("full qreq idle", 32'(qreq_a), 32'd0);
            if (c == 9) begin
                chk("full outst after pop", 32'(outst_a), 32'd6);
                chk("full ack", 32'(ack_a), 32'b0001);
                chk("full ackqid", 32'(ackqid_a), 32'h20);
                chk("full drop", 32'(drop_a), 32'd1);
                chk("full qreq new", 32'(qreq_a), 32'd1);
                chk("full qid new", 32'(qid_a), 32'h22);
            end
            poll_req = 4'hF;
            for (int k = 0; k < 4; k++) poll_qid[k*8 +: 8] = 8'(8'h20 + k);
            ll_ack          = (c == 7);
            queue_depth_ack = (c == 7);
            queue_depth     = 8'd50;
            ll_thr          = 9'd10;
            ll_mark_thr     = 9'd100;
            #1;
            if (c < 6)       chk($sformatf("full gnt c%0d", c), 32'(gnt_a), 32'(4'b0001 << (c % 4)));
            else if (c == 8) chk("full gnt on pop", 32'(gnt_a), 32'b0100);
            else             chk($sformatf("full gnt blocked c%0d", c), 32'(gnt_a), 32'd0);
        end
        poll_req = '0;

        // Depth return with nothing outstanding.
        do_reset();
        @(negedge clk);
        queue_depth_ack = 1'b1;
        queue_depth     = 8'd3;
        @(negedge clk);
        queue_depth_ack = 1'b0;
        chk("under0 ack c1", 32'(ack_a), 32'd0);
        @(negedge clk);
        chk("under0 ack c2", 32'(ack_a), 32'd0);
        chk("under0 err", 32'(err_a), 32'd1);
        chk("under0 err_ge", 32'(err_b), 32'd1);
        repeat (3) @(negedge clk);
        chk("under0 err sticky", 32'(err_a), 32'd1);
        chk("under0 outst", 32'(outst_a), 32'd0);

        // Depth return with a tag but no link-list info: nothing popped.
        do_reset();
        chk("under1 err cleared", 32'(err_a), 32'd0);
        @(negedge clk);
        poll_req      = 4'b0001;
        poll_qid[7:0] = 8'd7;
        @(negedge clk);
        poll_req        = '0;
        queue_depth_ack = 1'b1;
        chk("under1 qreq", 32'(qreq_a), 32'd1);
        @(negedge clk);
        queue_depth_ack = 1'b0;
        @(negedge clk);
        chk("under1 ack", 32'(ack_a), 32'd0);
        chk("under1 err", 32'(err_a), 32'd1);
        chk("under1 outst", 32'(outst_a), 32'd1);

        // Reset in the middle of three outstanding polls.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            poll_req       = 4'b0010;
            poll_qid[15:8] = 8'h31;
            #1;
            chk($sformatf("midrst gnt c%0d", c), 32'(gnt_a), 32'b0010);
        end
        @(negedge clk);
        poll_req = '0;
        chk("midrst outst", 32'(outst_a), 32'd3);
        chk("midrst qreq", 32'(qreq_a), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst r outst", 32'(outst_a), 32'd0);
        chk("midrst r qreq", 32'(qreq_a), 32'd0);
        chk("midrst r qid", 32'(qid_a), 32'd0);
        chk("midrst r gnt", 32'(gnt_a), 32'd0);
        chk("midrst r ack", 32'(ack_a), 32'd0);
        chk("midrst r ackqid", 32'(ackqid_a), 32'd0);
        chk("midrst r err", 32'(err_a), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_vec('{2, 8'd42, 1'b0, 9'd10, 9'd5, 8'd7, 1'b0, 1'b0, 1'b1, 1'b1}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
